// File: rtl/idli_io_m.sv
// idli_io_m: nibble-serial I/O port unit between the core datapath and the external
// din/dout nibble handshake pins.
//
// TX: 16-bit words from the core are buffered in a small FIFO and emitted as four
//     nibbles on o_io_dout, least significant nibble first.
// RX: four nibbles from i_io_din, least significant first, are assembled into a
//     16-bit word and held in o_io_rx_data until the core reads it.
//
// Ports:
//   i_io_gck        core clock, rising edge
//   i_io_rst_n      synchronous active-low reset
//   i_io_tx_data/i_io_tx_vld/o_io_tx_rdy     core -> TX FIFO word handshake
//   o_io_dout/o_io_dout_vld/i_io_dout_acp    TX nibble handshake to the pins
//   i_io_din/i_io_din_vld/o_io_din_acp       RX nibble handshake from the pins
//   o_io_rx_data/o_io_rx_vld/i_io_rx_rdy     assembled word -> core handshake
module idli_io_m #(
    parameter int unsigned TX_DEPTH = 2
) (
    input  logic        i_io_gck,
    input  logic        i_io_rst_n,
    input  logic [15:0] i_io_tx_data,
    input  logic        i_io_tx_vld,
    output logic        o_io_tx_rdy,
    output logic [3:0]  o_io_dout,
    output logic        o_io_dout_vld,
    input  logic        i_io_dout_acp,
    input  logic [3:0]  i_io_din,
    input  logic        i_io_din_vld,
    output logic        o_io_din_acp,
    output logic [15:0] o_io_rx_data,
    output logic        o_io_rx_vld,
    input  logic        i_io_rx_rdy
);

    localparam int unsigned AW = $clog2(TX_DEPTH);

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    logic [15:0] tx_mem_q [TX_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]  nib_q, nib_d;
    logic        tx_full, tx_empty, tx_push, tx_nib_take;
    logic [15:0] head_word;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign tx_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tx_empty = (wr_ptr_q == rd_ptr_q);

    assign o_io_tx_rdy   = !tx_full;
    assign o_io_dout_vld = !tx_empty;

    assign head_word = tx_mem_q[rd_ptr_q[AW-1:0]];
    assign o_io_dout = head_word[{nib_q, 2'b00} +: 4];

    assign tx_push     = i_io_tx_vld && !tx_full;
    assign tx_nib_take = !tx_empty && i_io_dout_acp;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        nib_d    = nib_q;
        if (tx_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (tx_nib_take) begin
            nib_d = nib_q + 2'd1;
            // Last nibble of the head word retires the entry.
            if (nib_q == 2'd3) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_io_gck) begin
        if (!i_io_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            nib_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            nib_q    <= nib_d;
        end
    end

    // Storage is cleared on reset so o_io_dout reads 0 out of reset.
    always_ff @(posedge i_io_gck) begin
        if (!i_io_rst_n) begin
            tx_mem_q <= '{default: '0};
        end else if (tx_push) begin
            tx_mem_q[wr_ptr_q[AW-1:0]] <= i_io_tx_data;
        end
    end

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    logic [15:0] asm_q, asm_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_full_q, rx_full_d;
    logic        rx_last, din_acp, rx_take;

    assign rx_last = (cnt_q == 2'd3);
    // Only the word-completing nibble can be refused, and only while the holding
    // register is occupied and not being drained this cycle.
    assign din_acp = !rx_last || !rx_full_q || i_io_rx_rdy;
    assign rx_take = i_io_din_vld && din_acp;

    assign o_io_din_acp = din_acp;
    assign o_io_rx_vld  = rx_full_q;
    assign o_io_rx_data = rx_data_q;

    always_comb begin
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        rx_data_d = rx_data_q;
        rx_full_d = rx_full_q;
        if (rx_full_q && i_io_rx_rdy) begin
            rx_full_d = 1'b0;
        end
        if (rx_take) begin
            asm_d[{cnt_q, 2'b00} +: 4] = i_io_din;
            cnt_d                      = cnt_q + 2'd1;
            // A completing word overrides the drain above in the same cycle.
            if (rx_last) begin
                rx_data_d = {i_io_din, asm_q[11:0]};
                rx_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_io_gck) begin
        if (!i_io_rst_n) begin
            asm_q     <= '0;
            cnt_q     <= '0;
            rx_data_q <= '0;
            rx_full_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            cnt_q     <= cnt_d;
            rx_data_q <= rx_data_d;
            rx_full_q <= rx_full_d;
        end
    end

endmodule

// File: tb/tb_idli_io_m.sv
// Testbench for idli_io_m: directed handshake scenarios plus random traffic, checked
// against nibble/word scoreboards filled when stimulus is accepted.
module tb_idli_io_m;

    localparam int unsigned TX_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_vld = 1'b0;
    logic        tx_rdy;
    logic [3:0]  dout;
    logic        dout_vld;
    logic        dout_acp = 1'b0;
    logic [3:0]  din = '0;
    logic        din_vld = 1'b0;
    logic        din_acp;
    logic [15:0] rx_data;
    logic        rx_vld;
    logic        rx_rdy = 1'b0;

    always #5 clk = ~clk;

    idli_io_m #(.TX_DEPTH(TX_DEPTH)) dut (
        .i_io_gck      (clk),
        .i_io_rst_n    (rst_n),
        .i_io_tx_data  (tx_data),
        .i_io_tx_vld   (tx_vld),
        .o_io_tx_rdy   (tx_rdy),
        .o_io_dout     (dout),
        .o_io_dout_vld (dout_vld),
        .i_io_dout_acp (dout_acp),
        .i_io_din      (din),
        .i_io_din_vld  (din_vld),
        .o_io_din_acp  (din_acp),
        .o_io_rx_data  (rx_data),
        .o_io_rx_vld   (rx_vld),
        .i_io_rx_rdy   (rx_rdy)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Scoreboards: expected nibbles on dout, expected words on rx_data.
    logic [3:0]  txq[$];
    logic [15:0] rxq[$];
    logic [15:0] rx_asm_m = '0;
    logic [1:0]  rx_cnt_m = '0;
    logic        tx_fire = 1'b0;
    logic        din_fire = 1'b0;
    int          tx_nib_got = 0;
    int          rx_word_got = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Runs at the falling edge: inputs and outputs are settled for the next rising edge.
    task automatic monitor();
        tx_fire  = 1'b0;
        din_fire = 1'b0;
        if (!rst_n) return;
        check_val("tx_rdy", 32'(tx_rdy), 32'(((txq.size() + 3) / 4) < TX_DEPTH));
        check_val("dout_vld", 32'(dout_vld), 32'(txq.size() != 0));
        if (dout_vld && txq.size() != 0) begin
            check_val("dout", 32'(dout), 32'(txq[0]));
            if (dout_acp) begin
                void'(txq.pop_front());
                tx_nib_got++;
            end
        end
        if (tx_vld && tx_rdy) begin
            tx_fire = 1'b1;
            for (int k = 0; k < 4; k++) txq.push_back(tx_data[4*k +: 4]);
        end
        check_val("rx_vld", 32'(rx_vld), 32'(rxq.size() != 0));
        check_val("din_acp", 32'(din_acp),
                  32'(!(rx_cnt_m == 2'd3 && rxq.size() != 0 && !rx_rdy)));
        if (rx_vld && rxq.size() != 0) begin
            check_val("rx_data", 32'(rx_data), 32'(rxq[0]));
            if (rx_rdy) begin
                void'(rxq.pop_front());
                rx_word_got++;
            end
        end
        if (din_vld && din_acp) begin
            din_fire = 1'b1;
            rx_asm_m[4*rx_cnt_m +: 4] = din;
            if (rx_cnt_m == 2'd3) rxq.push_back(rx_asm_m);
            rx_cnt_m = rx_cnt_m + 2'd1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        tx_vld  = 1'b0;
        din_vld = 1'b0;
        rst_n   = 1'b0;
        txq.delete();
        rxq.delete();
        rx_cnt_m = '0;
        rx_asm_m = '0;
        run(2);
        rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [15:0] w);
        logic ok = 1'b0;
        tx_vld  = 1'b1;
        tx_data = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            cycle();
            ok = tx_fire;
        end
        tx_vld = 1'b0;
        check_val("push_done", 32'(ok), 32'(1));
    endtask

    task automatic send_nib(input logic [3:0] n);
        logic ok = 1'b0;
        din_vld = 1'b1;
        din     = n;
        for (int i = 0; i < 200 && !ok; i++) begin
            cycle();
            ok = din_fire;
        end
        din_vld = 1'b0;
        check_val("nib_done", 32'(ok), 32'(1));
    endtask

    task automatic drain_tx();
        dout_acp = 1'b1;
        for (int i = 0; i < 200 && txq.size() != 0; i++) cycle();
        check_val("tx_drained", 32'(txq.size()), 32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset values.
        do_reset();
        check_val("rst_tx_rdy", 32'(tx_rdy), 32'(1));
        check_val("rst_dout_vld", 32'(dout_vld), 32'(0));
        check_val("rst_dout", 32'(dout), 32'(0));
        check_val("rst_din_acp", 32'(din_acp), 32'(1));
        check_val("rst_rx_vld", 32'(rx_vld), 32'(0));
        check_val("rst_rx_data", 32'(rx_data), 32'(0));

        // Single word streamed with continuous accept.
        dout_acp = 1'b1;
        push_word(16'hA5C3);
        check_val("t1_first_vld", 32'(dout_vld), 32'(1));
        check_val("t1_first_nib", 32'(dout), 32'(4'h3));
        run(5);
        check_val("t1_idle_vld", 32'(dout_vld), 32'(0));
        check_val("t1_idle_rdy", 32'(tx_rdy), 32'(1));

        // Fill the FIFO with accept held low; third word must wait.
        dout_acp = 1'b0;
        push_word(16'hA5C3);
        push_word(16'h8E71);
        check_val("t2_full_rdy", 32'(tx_rdy), 32'(0));
        tx_vld  = 1'b1;
        tx_data = 16'h2B9D;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("t2_refused", 32'(tx_fire), 32'(0));
            check_val("t2_hold_nib", 32'(dout), 32'(4'h3));
        end
        dout_acp = 1'b1;
        begin
            logic ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                cycle();
                ok = tx_fire;
            end
            check_val("t2_third_push", 32'(ok), 32'(1));
        end
        tx_vld = 1'b0;
        drain_tx();

        // Push coinciding with the last-nibble pop at occupancy 1.
        dout_acp = 1'b0;
        push_word(16'h1234);
        dout_acp = 1'b1;
        run(3);
        tx_vld  = 1'b1;
        tx_data = 16'hBEEF;
        cycle();
        check_val("t3_push", 32'(tx_fire), 32'(1));
        tx_vld   = 1'b0;
        dout_acp = 1'b0;
        check_val("t3_vld", 32'(dout_vld), 32'(1));
        check_val("t3_nib0", 32'(dout), 32'(4'hF));
        check_val("t3_occ", 32'(txq.size()), 32'(4));
        drain_tx();

        // RX assembly and back-pressure on the word-completing nibble.
        rx_rdy = 1'b0;
        send_nib(4'h1); send_nib(4'h2); send_nib(4'h3); send_nib(4'h4);
        check_val("t4_vld", 32'(rx_vld), 32'(1));
        check_val("t4_word", 32'(rx_data), 32'(16'h4321));
        send_nib(4'h5); send_nib(4'h6); send_nib(4'h7);
        din_vld = 1'b1;
        din     = 4'h8;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("t4_block", 32'(din_fire), 32'(0));
        end
        rx_rdy = 1'b1;
        cycle();
        check_val("t4_take", 32'(din_fire), 32'(1));
        din_vld = 1'b0;
        rx_rdy  = 1'b0;
        check_val("t4_vld_kept", 32'(rx_vld), 32'(1));
        check_val("t4_word2", 32'(rx_data), 32'(16'h8765));
        rx_rdy = 1'b1;
        cycle();
        rx_rdy = 1'b0;

        // Reset with partial words in flight.
        dout_acp = 1'b1;
        push_word(16'hCAFE);
        run(2);
        dout_acp = 1'b0;
        send_nib(4'h1);
        send_nib(4'h2);
        do_reset();
        check_val("t5_tx_rdy", 32'(tx_rdy), 32'(1));
        check_val("t5_dout_vld", 32'(dout_vld), 32'(0));
        check_val("t5_dout", 32'(dout), 32'(0));
        check_val("t5_rx_vld", 32'(rx_vld), 32'(0));
        check_val("t5_din_acp", 32'(din_acp), 32'(1));
        send_nib(4'h9); send_nib(4'hA); send_nib(4'hB); send_nib(4'hC);
        check_val("t5_word", 32'(rx_data), 32'(16'hCBA9));
        rx_rdy = 1'b1;
        cycle();
        rx_rdy = 1'b0;

        // Random traffic in both directions.
        begin
            int tx_sent = 0;
            int rx_sent = 0;
            int cyc = 0;
            tx_nib_got  = 0;
            rx_word_got = 0;
            while ((tx_sent < 1000 || rx_sent < 4000 || txq.size() != 0 || rxq.size() != 0 ||
                    tx_vld || din_vld) && cyc < 60000) begin
                dout_acp = 1'($urandom_range(0, 1));
                rx_rdy   = 1'($urandom_range(0, 1));
                if (!tx_vld && tx_sent < 1000 && $urandom_range(0, 3) != 0) begin
                    tx_vld  = 1'b1;
                    tx_data = 16'($urandom);
                end
                if (!din_vld && rx_sent < 4000 && $urandom_range(0, 3) != 0) begin
                    din_vld = 1'b1;
                    din     = 4'($urandom);
                end
                cycle();
                cyc++;
                if (tx_fire) begin
                    tx_sent++;
                    tx_vld = 1'b0;
                end
                if (din_fire) begin
                    rx_sent++;
                    din_vld = 1'b0;
                end
            end
            check_val("rnd_bound", 32'(cyc < 60000), 32'(1));
            check_val("rnd_tx_sent", 32'(tx_sent), 32'(1000));
            check_val("rnd_tx_got", 32'(tx_nib_got), 32'(4000));
            check_val("rnd_rx_sent", 32'(rx_sent), 32'(4000));
            check_val("rnd_rx_got", 32'(rx_word_got), 32'(1000));
            check_val("rnd_txq_empty", 32'(txq.size()), 32'(0));
            check_val("rnd_rxq_empty", 32'(rxq.size()), 32'(0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
